// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the byte-wide memory port arbiter: access sizes, FSM states
// and the IO address window.
package mem_port_arbiter_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_READ    = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_IO_WAIT = 2'd3;

  // Address bits that select the uart window.
  localparam logic [31:0] IO_MASK = 32'h0003_0000;

  // Index of the final byte of an access of the given size.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_packer.sv
// Byte-lane helper: address of byte idx, store byte to shift out, and the read
// buffer with the incoming byte merged into lane idx.
module mem_byte_packer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [1:0]        idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rbuf,
  input  logic [7:0]        din,
  output logic [ADDR_W-1:0] byte_addr,
  output logic [7:0]        wbyte,
  output logic [DATA_W-1:0] merged
);
  logic [4:0] sh;

  assign sh        = {idx, 3'b000};
  assign byte_addr = base + ADDR_W'(idx);
  assign wbyte     = wdata[sh +: 8];
  assign merged    = rbuf | (DATA_W'(din) << sh);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM/IO port between instruction fetch, loads and the
// committed-store drain; each access runs as a series of single-byte port cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              flush,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_done,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [1:0]        load_size,
  output logic              load_done,
  output logic [DATA_W-1:0] load_data,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [1:0]        store_size,
  input  logic [DATA_W-1:0] store_data,
  output logic              store_done
);
  logic [1:0]        state, cnt, last, idx;
  logic [ADDR_W-1:0] base, byte_addr;
  logic [DATA_W-1:0] wdata, rbuf, merged;
  logic [7:0]        wbyte;
  logic              src_load, wr_q;
  logic              gnt_store, gnt_load, gnt_fetch;

  function automatic logic is_io(input logic [ADDR_W-1:0] a);
    return (a & ADDR_W'(IO_MASK)) == ADDR_W'(IO_BASE);
  endfunction

  // A requester whose done is still pulsing is masked, so the port gets one idle cycle.
  always_comb begin
    gnt_store = store_req && !store_done;
    gnt_load  = !gnt_store && load_req && !load_done && !flush;
    gnt_fetch = !gnt_store && !gnt_load && fetch_req && !fetch_done && !flush;
  end

  // Normal writes put byte 0 out at grant, so the FSM steps to the next lane.
  assign idx    = (state == ST_WRITE) ? cnt + 2'd1 : cnt;
  assign mem_wr = wr_q & rdy;

  mem_byte_packer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_packer (
    .base(base), .idx(idx), .wdata(wdata), .rbuf(rbuf), .din(mem_din),
    .byte_addr(byte_addr), .wbyte(wbyte), .merged(merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last       <= '0;
      base       <= '0;
      wdata      <= '0;
      rbuf       <= '0;
      src_load   <= FALSE;
      wr_q       <= FALSE;
      mem_a      <= '0;
      mem_dout   <= '0;
      fetch_done <= FALSE;
      load_done  <= FALSE;
      store_done <= FALSE;
      fetch_data <= '0;
      load_data  <= '0;
    end else if (rdy) begin
      fetch_done <= FALSE;
      load_done  <= FALSE;
      store_done <= FALSE;
      case (state)
        ST_IDLE: begin
          wr_q <= FALSE;
          cnt  <= '0;
          if (gnt_store) begin
            base  <= store_addr;
            wdata <= store_data;
            last  <= last_idx(store_size);
            if (is_io(store_addr)) begin
              state <= ST_IO_WAIT;
            end else begin
              state    <= ST_WRITE;
              wr_q     <= TRUE;
              mem_a    <= store_addr;
              mem_dout <= store_data[7:0];
            end
          end else if (gnt_load || gnt_fetch) begin
            state    <= ST_READ;
            src_load <= gnt_load;
            rbuf     <= '0;
            base     <= gnt_load ? load_addr : fetch_addr;
            mem_a    <= gnt_load ? load_addr : fetch_addr;
            last     <= gnt_load ? last_idx(load_size) : 2'd3;
          end
        end
        ST_READ: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (cnt == last) begin
            state <= ST_IDLE;
            if (src_load) begin
              load_done <= TRUE;
              load_data <= merged;
            end else begin
              fetch_done <= TRUE;
              fetch_data <= merged;
            end
          end else begin
            rbuf  <= merged;
            cnt   <= cnt + 2'd1;
            mem_a <= byte_addr + ADDR_W'(1);
          end
        end
        ST_WRITE: begin
          if (cnt == last) begin
            wr_q       <= FALSE;
            store_done <= TRUE;
            state      <= ST_IDLE;
          end else begin
            cnt      <= cnt + 2'd1;
            mem_a    <= byte_addr;
            mem_dout <= wbyte;
          end
        end
        ST_IO_WAIT: begin
          // The uart full flag lags one cycle, so every IO write is followed by a gap.
          if (wr_q) begin
            wr_q <= FALSE;
            if (cnt == last) begin
              store_done <= TRUE;
              state      <= ST_IDLE;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end else if (!io_buffer_full) begin
            wr_q     <= TRUE;
            mem_a    <= byte_addr;
            mem_dout <= wbyte;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: byte-addressed RAM model with a one-cycle
// read path, scenario tasks with hand-computed expectations.
module tb_mem_port_arbiter;
  logic        clk, rst, rdy;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full, flush;
  logic        fetch_req, fetch_done;
  logic [31:0] fetch_addr, fetch_data;
  logic        load_req, load_done;
  logic [31:0] load_addr, load_data;
  logic [1:0]  load_size;
  logic        store_req, store_done;
  logic [31:0] store_addr, store_data;
  logic [1:0]  store_size;

  int tests = 0;
  int fails = 0;
  int nwr   = 0;

  logic [7:0] ram [0:1023];

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .flush(flush),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
    .fetch_data(fetch_data), .load_req(load_req), .load_addr(load_addr),
    .load_size(load_size), .load_done(load_done), .load_data(load_data),
    .store_req(store_req), .store_addr(store_addr), .store_size(store_size),
    .store_data(store_data), .store_done(store_done)
  );

  assign mem_din = ram[mem_a[9:0]];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wr) nwr <= nwr + 1;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int which, input int maxc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if ((which == 0 && fetch_done) || (which == 1 && load_done) ||
          (which == 2 && store_done)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL reset_mem_wr got %b exp 0", mem_wr); end
    tests++; if (mem_a !== 32'h0) begin fails++; $display("FAIL reset_mem_a got %h exp 0", mem_a); end
    tests++; if (mem_dout !== 8'h0) begin fails++; $display("FAIL reset_mem_dout got %h exp 0", mem_dout); end
    tests++; if ({fetch_done, load_done, store_done} !== 3'b000) begin
      fails++; $display("FAIL reset_done got %b exp 000", {fetch_done, load_done, store_done}); end
  endtask

  task automatic test_fetch();
    fetch_addr = 32'h100; fetch_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        tests++; if (mem_a !== 32'h100 + k - 1) begin fails++; $display("FAIL fetch_addr k=%0d got %h exp %h", k, mem_a, 32'h100 + k - 1); end
        tests++; if (fetch_done !== 1'b0) begin fails++; $display("FAIL fetch_early_done k=%0d got %b exp 0", k, fetch_done); end
      end else if (k == 5) begin
        tests++; if (fetch_done !== 1'b1 || fetch_data !== 32'h0000_0513) begin
          fails++; $display("FAIL fetch_done got %b/%h exp 1/00000513", fetch_done, fetch_data); end
        fetch_req = 1'b0;
      end else begin
        tests++; if (fetch_done !== 1'b0) begin fails++; $display("FAIL fetch_pulse got %b exp 0", fetch_done); end
      end
    end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] exp_a [4];
    int cyc;
    exp_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    fetch_addr = 32'hFFFF_FFFE; fetch_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++; if (mem_a !== exp_a[k]) begin fails++; $display("FAIL wrap_addr k=%0d got %h exp %h", k, mem_a, exp_a[k]); end
    end
    wait_done(0, 4, cyc);
    tests++; if (cyc !== 1 || fetch_data !== 32'hDDCC_BBAA) begin
      fails++; $display("FAIL wrap_data cyc=%0d got %h exp 1/ddccbbaa", cyc, fetch_data); end
    fetch_req = 1'b0; idle(1);
  endtask

  task automatic test_load_vs_fetch();
    load_addr = 32'h200; load_size = 2'd2; load_req = 1'b1;
    fetch_addr = 32'h100; fetch_req = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) begin
        tests++; if (mem_a !== 32'h200) begin fails++; $display("FAIL prio_load_first got %h exp 200", mem_a); end
      end
      if (k == 5) begin
        tests++; if (load_done !== 1'b1 || load_data !== 32'h1234_5678) begin
          fails++; $display("FAIL prio_load_done got %b/%h exp 1/12345678", load_done, load_data); end
        load_req = 1'b0;
      end
      if (k == 6) begin
        tests++; if (mem_a !== 32'h100 || load_done !== 1'b0) begin
          fails++; $display("FAIL prio_fetch_grant got %h/%b exp 100/0", mem_a, load_done); end
      end
      if (k < 10) begin
        tests++; if (fetch_done !== 1'b0) begin fails++; $display("FAIL prio_fetch_early k=%0d got %b exp 0", k, fetch_done); end
      end
      if (k == 10) begin
        tests++; if (fetch_done !== 1'b1 || fetch_data !== 32'h0000_0513) begin
          fails++; $display("FAIL prio_fetch_done got %b/%h exp 1/00000513", fetch_done, fetch_data); end
        fetch_req = 1'b0;
      end
    end
  endtask

  task automatic test_store_word();
    logic [31:0] w;
    w = 32'hDEAD_BEEF;
    store_addr = 32'h300; store_size = 2'd2; store_data = w; store_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        tests++; if (mem_wr !== 1'b1 || mem_a !== 32'h300 + k - 1 || mem_dout !== w[8*(k-1) +: 8]) begin
          fails++; $display("FAIL store_byte k=%0d got wr=%b a=%h d=%h exp 1/%h/%h", k, mem_wr, mem_a, mem_dout,
                            32'h300 + k - 1, w[8*(k-1) +: 8]); end
      end else if (k == 5) begin
        tests++; if (mem_wr !== 1'b0 || store_done !== 1'b1) begin
          fails++; $display("FAIL store_done got wr=%b done=%b exp 0/1", mem_wr, store_done); end
        store_req = 1'b0;
      end else begin
        tests++; if (store_done !== 1'b0) begin fails++; $display("FAIL store_pulse got %b exp 0", store_done); end
      end
    end
  endtask

  task automatic test_store_over_load();
    int cyc;
    store_addr = 32'h308; store_size = 2'd0; store_data = 32'h77; store_req = 1'b1;
    load_addr = 32'h200; load_size = 2'd2; load_req = 1'b1;
    @(negedge clk);
    tests++; if (mem_wr !== 1'b1 || mem_a !== 32'h308 || mem_dout !== 8'h77) begin
      fails++; $display("FAIL sprio_store got %b/%h/%h exp 1/308/77", mem_wr, mem_a, mem_dout); end
    @(negedge clk);
    tests++; if (store_done !== 1'b1 || mem_wr !== 1'b0) begin
      fails++; $display("FAIL sprio_done got %b/%b exp 1/0", store_done, mem_wr); end
    store_req = 1'b0;
    @(negedge clk);
    tests++; if (mem_a !== 32'h200 || mem_wr !== 1'b0) begin
      fails++; $display("FAIL sprio_load_grant got %h/%b exp 200/0", mem_a, mem_wr); end
    wait_done(1, 8, cyc);
    tests++; if (cyc !== 4 || load_data !== 32'h1234_5678) begin
      fails++; $display("FAIL sprio_load_done cyc=%0d data=%h exp 4/12345678", cyc, load_data); end
    load_req = 1'b0; idle(1);
  endtask

  task automatic test_io_store();
    int n0;
    logic exp_wr [5];
    n0 = nwr;
    io_buffer_full = 1'b1;
    store_addr = 32'h3_0000; store_size = 2'd0; store_data = 32'h41; store_req = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL io_full_wr k=%0d got %b exp 0", k, mem_wr); end
        if (k == 3) io_buffer_full = 1'b0;
      end else if (k == 4) begin
        tests++; if (mem_wr !== 1'b1 || mem_a !== 32'h3_0000 || mem_dout !== 8'h41) begin
          fails++; $display("FAIL io_write got %b/%h/%h exp 1/30000/41", mem_wr, mem_a, mem_dout); end
      end else if (k == 5) begin
        tests++; if (mem_wr !== 1'b0 || store_done !== 1'b1) begin
          fails++; $display("FAIL io_done got %b/%b exp 0/1", mem_wr, store_done); end
        store_req = 1'b0;
      end
    end
    tests++; if (nwr - n0 !== 1) begin fails++; $display("FAIL io_write_count got %0d exp 1", nwr - n0); end
    // Half-word to the uart: writes must be separated by an idle cycle.
    exp_wr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    store_addr = 32'h3_0004; store_size = 2'd1; store_data = 32'h4443; store_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++; if (mem_wr !== exp_wr[k]) begin fails++; $display("FAIL io_gap k=%0d got %b exp %b", k, mem_wr, exp_wr[k]); end
      if (k == 1 || k == 3) begin
        tests++; if (mem_a !== 32'h3_0004 + (k - 1) / 2 || mem_dout !== ((k == 1) ? 8'h43 : 8'h44)) begin
          fails++; $display("FAIL io_half_byte k=%0d got %h/%h", k, mem_a, mem_dout); end
      end
      if (k == 4) begin
        tests++; if (store_done !== 1'b1) begin fails++; $display("FAIL io_half_done got %b exp 1", store_done); end
        store_req = 1'b0;
      end
    end
    idle(1);
  endtask

  task automatic test_flush_and_sizes();
    int cyc;
    fetch_addr = 32'h100; fetch_req = 1'b1;
    for (int k = 1; k <= 3; k++) @(negedge clk);
    tests++; if (mem_a !== 32'h102) begin fails++; $display("FAIL flush_pre got %h exp 102", mem_a); end
    flush = 1'b1; fetch_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    tests++; if (mem_a !== 32'h102 || mem_wr !== 1'b0) begin
      fails++; $display("FAIL flush_hold got %h/%b exp 102/0", mem_a, mem_wr); end
    for (int k = 0; k < 3; k++) begin
      tests++; if (fetch_done !== 1'b0) begin fails++; $display("FAIL flush_no_done k=%0d got %b exp 0", k, fetch_done); end
      @(negedge clk);
    end
    load_addr = 32'h201; load_size = 2'd0; load_req = 1'b1;
    wait_done(1, 4, cyc);
    tests++; if (cyc !== 2 || load_data !== 32'h0000_0056) begin
      fails++; $display("FAIL load_byte cyc=%0d data=%h exp 2/00000056", cyc, load_data); end
    load_req = 1'b0; idle(1);
    load_addr = 32'h202; load_size = 2'd1; load_req = 1'b1;
    wait_done(1, 5, cyc);
    tests++; if (cyc !== 3 || load_data !== 32'h0000_1234) begin
      fails++; $display("FAIL load_half cyc=%0d data=%h exp 3/00001234", cyc, load_data); end
    load_req = 1'b0; idle(1);
    // A flush in the arbitration cycle blocks the fetch grant.
    fetch_addr = 32'h100; fetch_req = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++; if (mem_a !== 32'h203) begin fails++; $display("FAIL flush_no_grant got %h exp 203", mem_a); end
    wait_done(0, 8, cyc);
    tests++; if (cyc !== 5 || fetch_data !== 32'h0000_0513) begin
      fails++; $display("FAIL flush_regrant cyc=%0d data=%h exp 5/00000513", cyc, fetch_data); end
    fetch_req = 1'b0; idle(1);
  endtask

  task automatic test_rdy_stall();
    int cyc;
    load_addr = 32'h200; load_size = 2'd2; load_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rdy = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      tests++; if (mem_a !== 32'h201 || load_done !== 1'b0) begin
        fails++; $display("FAIL stall_frozen k=%0d got %h/%b exp 201/0", k, mem_a, load_done); end
    end
    rdy = 1'b1;
    wait_done(1, 6, cyc);
    tests++; if (cyc !== 3 || load_data !== 32'h1234_5678) begin
      fails++; $display("FAIL stall_load cyc=%0d data=%h exp 3/12345678", cyc, load_data); end
    rdy = 1'b0;
    @(negedge clk);
    tests++; if (load_done !== 1'b1 || load_data !== 32'h1234_5678) begin
      fails++; $display("FAIL stall_done_held got %b/%h exp 1/12345678", load_done, load_data); end
    rdy = 1'b1; load_req = 1'b0;
    @(negedge clk);
    tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL stall_done_clear got %b exp 0", load_done); end
    store_addr = 32'h304; store_size = 2'd2; store_data = 32'hA1B2_C3D4; store_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
    tests++; if (mem_wr !== 1'b0 || mem_a !== 32'h305) begin
      fails++; $display("FAIL stall_wr_gate got %b/%h exp 0/305", mem_wr, mem_a); end
    rdy = 1'b1;
    @(negedge clk);
    tests++; if (mem_wr !== 1'b1 || mem_a !== 32'h306 || mem_dout !== 8'hB2) begin
      fails++; $display("FAIL stall_wr_resume got %b/%h/%h exp 1/306/b2", mem_wr, mem_a, mem_dout); end
    wait_done(2, 4, cyc);
    tests++; if (cyc !== 2) begin fails++; $display("FAIL stall_store_done cyc=%0d exp 2", cyc); end
    store_req = 1'b0; idle(1);
  endtask

  task automatic test_reset_mid_store();
    store_addr = 32'h300; store_size = 2'd2; store_data = 32'hDEAD_BEEF; store_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0) begin
      fails++; $display("FAIL async_rst_port got %b/%h/%h exp 0/0/0", mem_wr, mem_a, mem_dout); end
    tests++; if (store_done !== 1'b0 || load_data !== 32'h0 || fetch_data !== 32'h0) begin
      fails++; $display("FAIL async_rst_data got %b/%h/%h exp 0/0/0", store_done, load_data, fetch_data); end
    store_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (mem_wr !== 1'b0 || mem_a !== 32'h0) begin
      fails++; $display("FAIL post_rst_idle got %b/%h exp 0/0", mem_wr, mem_a); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; rdy = 1'b1;
    io_buffer_full = 1'b0; flush = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    load_req = 1'b0; load_addr = '0; load_size = '0;
    store_req = 1'b0; store_addr = '0; store_size = '0; store_data = '0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h05;
    ram[10'h200] = 8'h78; ram[10'h201] = 8'h56; ram[10'h202] = 8'h34; ram[10'h203] = 8'h12;
    ram[10'h3FE] = 8'hAA; ram[10'h3FF] = 8'hBB; ram[10'h000] = 8'hCC; ram[10'h001] = 8'hDD;
    idle(2);
    test_reset();
    rst = 1'b0;
    idle(1);
    test_fetch();
    test_addr_wrap();
    test_load_vs_fetch();
    test_store_word();
    test_store_over_load();
    test_io_store();
    test_flush_and_sizes();
    test_rdy_stall();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
